// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared Booth multiplier controller.
package mult_share_pkg;

   localparam int DEF_NREQ  = 2;
   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NOP,
      ADD,
      SUB
   } booth_op_t;

   // Radix-2 Booth recoding of the current multiplier LSB and the bit shifted out last step.
   function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
      case ({q0, q_1})
         2'b01:   return ADD;
         2'b10:   return SUB;
         default: return NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step_dp.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic shift right of the whole {A,Q,q_1} chain.
module booth_step_dp
   import mult_share_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   a_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic             q1_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH:0]   a_out,
   output logic [WIDTH-1:0] q_out,
   output logic             q1_out
);

   // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;
   booth_op_t      op;

   assign m_ext = {m_in[WIDTH-1], m_in};

   // Add/sub selected by the Booth pair, then shift the chain right by one with sign fill.
   always_comb begin
      op = booth_decode(q_in[0], q1_in);
      case (op)
         ADD:     sum = a_in + m_ext;
         SUB:     sum = a_in - m_ext;
         default: sum = a_in;
      endcase
      a_out  = {sum[WIDTH], sum[WIDTH:1]};
      q_out  = {sum[0], q_in[WIDTH-1:1]};
      q1_out = q_in[0];
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin front end sharing one sequential signed Booth multiplier
// between NREQ requesters; reports each product with the requester's id.
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    multiplicand,
   input  logic [NREQ*WIDTH-1:0]    multiplier,
   output logic [NREQ-1:0]          gnt,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(NREQ)-1:0]  done_id,
   output logic [WIDTH-1:0]         HI_FF,
   output logic [WIDTH-1:0]         LO_FF
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q1_reg;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  idx;
   logic             last_step;

   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;
   logic             q1_next;

   booth_step_dp #(.WIDTH(WIDTH)) u_step (
      .a_in   (a_reg),
      .q_in   (q_reg),
      .q1_in  (q1_reg),
      .m_in   (m_reg),
      .a_out  (a_next),
      .q_out  (q_next),
      .q1_out (q1_next)
   );

   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // Round-robin pick: first pending requester above rr_ptr, wrapping; the
   // descending scan lets the nearest candidate overwrite farther ones.
   always_comb begin
      winner = rr_ptr;
      idx    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NREQ);
         if (req[idx]) winner = idx;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and status outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (|req) state_next = ITER;
         ITER: begin
            busy = 1'b1;
            if (last_step) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, Booth iteration registers, grant pulse and result registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
      if (reset) begin
         m_reg   <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         q1_reg  <= 1'b0;
         cnt     <= '0;
         rr_ptr  <= ID_W'(NREQ - 1);
         gnt     <= '0;
         done_id <= '0;
         HI_FF   <= '0;
         LO_FF   <= '0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  m_reg  <= multiplicand[int'(winner)*WIDTH +: WIDTH];
                  q_reg  <= multiplier[int'(winner)*WIDTH +: WIDTH];
                  a_reg  <= '0;
                  q1_reg <= 1'b0;
                  cnt    <= '0;
                  rr_ptr <= winner;
                  gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
               end
            end
            ITER: begin
               a_reg  <= a_next;
               q_reg  <= q_next;
               q1_reg <= q1_next;
               cnt    <= cnt + 1'b1;
               if (last_step) begin
                  HI_FF   <= a_next[WIDTH-1:0];
                  LO_FF   <= q_next;
                  done_id <= rr_ptr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (NREQ=2, WIDTH=4): products, latency,
// round-robin order, mid-job requests, reset abort and a full operand sweep.
module tb_mult_share_ctrl;

   localparam int NREQ  = 2;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] multiplicand;
   logic [NREQ*WIDTH-1:0] multiplier;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  done;
   logic [0:0]            done_id;
   logic [WIDTH-1:0]      HI_FF;
   logic [WIDTH-1:0]      LO_FF;

   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;
   logic prev_done = 1'b0;

   logic [NREQ-1:0] g;
   int              cyc;

   always #5 clk = ~clk;

   mult_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .gnt          (gnt),
      .busy         (busy),
      .done         (done),
      .done_id      (done_id),
      .HI_FF        (HI_FF),
      .LO_FF        (LO_FF)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per-cycle exclusivity checks on the falling edge.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("gnt_done_excl", 32'(|gnt & done), 32'(0));
         check("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
         check("done_needs_busy", 32'(done & ~busy), 32'(0));
         check("done_pulse", 32'(prev_done & done), 32'(0));
      end
      prev_done = done;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string tag, output logic [NREQ-1:0] gv, output int c);
      gv = '0;
      c  = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         c++;
         if (|gnt) begin
            gv = gnt;
            break;
         end
      end
      if (gv == '0) check({tag, "_gnt_timeout"}, 32'(1), 32'(0));
   endtask

   task automatic wait_done(input string tag, output int c);
      logic seen;
      seen = 1'b0;
      c    = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         c++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_done_timeout"}, 32'(1), 32'(0));
   endtask

   task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
      multiplicand[id*WIDTH +: WIDTH] = a;
      multiplier[id*WIDTH +: WIDTH]   = b;
   endtask

   // One isolated job from an idle arbiter: 1-cycle grant, done WIDTH cycles after gnt.
   task automatic run_job(input string tag, input int id, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp);
      logic [NREQ-1:0] gl;
      int              cl;
      tick();
      set_ops(id, a, b);
      req = NREQ'(1) << id;
      wait_gnt(tag, gl, cl);
      req = '0;
      check({tag, "_gnt"}, 32'(gl), 32'(NREQ'(1) << id));
      check({tag, "_gnt_lat"}, 32'(cl), 32'(1));
      wait_done(tag, cl);
      check({tag, "_done_lat"}, 32'(cl), 32'(WIDTH));
      check({tag, "_id"}, 32'(done_id), 32'(id));
      check({tag, "_prod"}, 32'({HI_FF, LO_FF}), 32'(exp));
   endtask

   initial begin
      logic [3:0]        ai, bi;
      logic signed [7:0] sa, sb, sp;
      logic [0:0]        exp_id;

      reset        = 1'b1;
      req          = '0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) tick();
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_done_id", 32'(done_id), 32'(0));
      check("rst_hi", 32'(HI_FF), 32'(0));
      check("rst_lo", 32'(LO_FF), 32'(0));
      reset  = 1'b0;
      mon_en = 1'b1;

      // Directed products: -1*-7=+7, -8*-8=+64, 7*-8=-56.
      run_job("m1x7", 0, 4'b1111, 4'b1001, 8'h07);
      run_job("m8x8", 1, 4'b1000, 4'b1000, 8'h40);
      run_job("p7xm8", 1, 4'b0111, 4'b1000, 8'hC8);

      // Both requesting continuously: 3*-2=-6 for req0, -5*6=-30 for req1.
      tick();
      set_ops(0, 4'b0011, 4'b1110);
      set_ops(1, 4'b1011, 4'b0110);
      req = 2'b11;
      for (int j = 0; j < 4; j++) begin
         exp_id = (j % 2 == 1);
         wait_gnt("rr", g, cyc);
         if (j == 3) req = '0;
         check("rr_gnt", 32'(g), 32'(2'b01 << exp_id));
         wait_done("rr", cyc);
         check("rr_id", 32'(done_id), 32'(exp_id));
         check("rr_prod", 32'({HI_FF, LO_FF}), exp_id ? 32'(8'hE2) : 32'(8'hFA));
      end

      // req0 arrives while req1's job (5*3=15) is running; req0 job is -2*-3=6.
      tick();
      set_ops(1, 4'b0101, 4'b0011);
      set_ops(0, 4'b1110, 4'b1101);
      req = 2'b10;
      wait_gnt("mid", g, cyc);
      check("mid_gnt", 32'(g), 32'(2'b10));
      req = 2'b01;
      for (int j = 0; j < 4; j++) begin
         tick();
         check("mid_no_gnt", 32'(gnt), 32'(0));
      end
      check("mid_done", 32'(done), 32'(1));
      check("mid_prod", 32'({HI_FF, LO_FF}), 32'(8'h0F));
      tick();
      check("mid_idle_gnt", 32'(gnt), 32'(0));
      check("mid_idle_busy", 32'(busy), 32'(0));
      tick();
      check("mid_gnt0", 32'(gnt), 32'(2'b01));
      req = '0;
      wait_done("mid0", cyc);
      check("mid0_lat", 32'(cyc), 32'(WIDTH));
      check("mid0_prod", 32'({HI_FF, LO_FF}), 32'(8'h06));

      // Reset in the second ITER cycle aborts the job and restores rr_ptr.
      tick();
      set_ops(1, 4'b0111, 4'b0111);
      set_ops(0, 4'b0110, 4'b1101);
      req = 2'b11;
      wait_gnt("abort", g, cyc);
      check("abort_gnt", 32'(g), 32'(2'b10));
      req = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_gnt_low", 32'(gnt), 32'(0));
      check("abort_hi", 32'(HI_FF), 32'(0));
      check("abort_lo", 32'(LO_FF), 32'(0));
      for (int j = 0; j < 8; j++) begin
         tick();
         check("abort_no_done", 32'(done), 32'(0));
      end
      req = 2'b11;
      wait_gnt("post", g, cyc);
      req = '0;
      check("post_gnt", 32'(g), 32'(2'b01));
      check("post_gnt_lat", 32'(cyc), 32'(1));
      wait_done("post", cyc);
      check("post_prod", 32'({HI_FF, LO_FF}), 32'(8'hEE));

      // Every signed 4x4 pair against a plain signed multiply.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ai = a[3:0];
            bi = b[3:0];
            sa = {{4{ai[3]}}, ai};
            sb = {{4{bi[3]}}, bi};
            sp = sa * sb;
            run_job("sweep", (a * 16 + b) % 2, ai, bi, sp);
         end
      end

      tick();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
